// File: rtl/flash_boot_loader.sv
// ---------------------------------------------------------------------------
// flash_boot_loader
//
// Post-reset boot sequencer. Issues a single SPI NOR READ (0x03) at
// FLASH_BASE, streams BOOT_WORDS little-endian 32-bit words out of the flash
// and writes each one into on-chip RAM through a Wishbone write master. The
// CPU is held in reset until the copy has finished. While a RAM write is
// pending, SCK is parked low with CSn still asserted, so the flash read
// stream pauses and resumes without a new command.
//
// Optional feature (macro FLASH_BOOT_CHECKSUM_EN): a modulo-2^32 sum of all
// written words is compared against one extra trailer word read from flash.
// On a mismatch, o_boot_err is raised and the CPU stays in reset.
//
// Ports:
//   wb_clk        system clock
//   i_rstn        asynchronous active-low reset
//   i_boot_en     sampled in IDLE: 1 = copy image, 0 = skip straight to DONE
//   o_flash_SCK   SPI clock (mode 0)
//   o_flash_CSn   flash chip select, active low
//   o_flash_MOSI  SPI data to flash, MSB first
//   i_flash_MISO  SPI data from flash
//   o_wb_adr      RAM word address (word index)
//   o_wb_dat      RAM write data
//   o_wb_sel      byte enables, 4'hF while o_wb_cyc=1
//   o_wb_we       write strobe, equal to o_wb_cyc
//   o_wb_cyc      combined cyc/stb bus request
//   i_wb_ack      write acknowledge (ignored outside WRITE)
//   o_cpu_rst     CPU reset, active high
//   o_done        boot finished
//   o_boot_err    checksum failure (tied 0 without FLASH_BOOT_CHECKSUM_EN)
// ---------------------------------------------------------------------------
module flash_boot_loader #(
    parameter logic [23:0] FLASH_BASE = 24'h10_0000,
    parameter int          BOOT_WORDS = 2048,
    parameter int          CLK_DIV    = 2,
    parameter int          AW         = 11
) (
    input  logic          wb_clk,
    input  logic          i_rstn,
    input  logic          i_boot_en,
    output logic          o_flash_SCK,
    output logic          o_flash_CSn,
    output logic          o_flash_MOSI,
    input  logic          i_flash_MISO,
    output logic [AW-1:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_cyc,
    input  logic          i_wb_ack,
    output logic          o_cpu_rst,
    output logic          o_done,
    output logic          o_boot_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_DATA, S_WRITE, S_FINISH, S_DONE
    } state_t;

    localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(BOOT_WORDS - 1);
    localparam logic [7:0]    READ_CMD = 8'h03;

    state_t          state_q, state_d;
    logic [7:0]      div_q, div_d;      // cycles elapsed in the current SCK phase
    logic [5:0]      bit_q, bit_d;      // bits completed (counted on falling edges)
    logic [31:0]     cmd_q, cmd_d;      // command shifter; MOSI is its MSB
    logic [6:0]      byte_q, byte_d;    // first 7 bits of the byte in flight
    logic [31:0]     word_q, word_d;    // assembled word, doubles as write data
    logic [AW-1:0]   idx_q, idx_d;
    logic            sck_q, sck_d;
    logic            csn_q, csn_d;
    logic            cyc_q, cyc_d;
    logic            done_q, done_d;
    logic            cpu_rst_q, cpu_rst_d;
`ifdef FLASH_BOOT_CHECKSUM_EN
    logic [31:0]     sum_q, sum_d;
    logic            trailer_q, trailer_d;  // current DATA word is the checksum
    logic            err_q, err_d;
`endif

    logic div_tick;
    assign div_tick = (div_q == DIV_LAST);

    // NOTE: every signal written here gets its default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        cmd_d     = cmd_q;
        byte_d    = byte_q;
        word_d    = word_q;
        idx_d     = idx_q;
        sck_d     = sck_q;
        csn_d     = csn_q;
        cyc_d     = cyc_q;
        done_d    = done_q;
        cpu_rst_d = cpu_rst_q;
`ifdef FLASH_BOOT_CHECKSUM_EN
        sum_d     = sum_q;
        trailer_d = trailer_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_boot_en) begin
                    csn_d   = 1'b0;
                    cmd_d   = {READ_CMD, FLASH_BASE};
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = S_CMD;
                end else begin
                    done_d    = 1'b1;
                    cpu_rst_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_CMD: begin
                if (div_tick) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (sck_q) begin
                        // Falling edge: present the next command bit. After 32
                        // shifts the register is empty, so MOSI idles at 0.
                        cmd_d = {cmd_q[30:0], 1'b0};
                        if (bit_q == 6'd31) begin
                            bit_d   = '0;
                            state_d = S_DATA;
                        end else begin
                            bit_d = bit_q + 6'd1;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_DATA: begin
                if (div_tick) begin
                    div_d = '0;
                    if (!sck_q && bit_q == 6'd32) begin
                        // Final low phase after the 32nd bit has elapsed.
`ifdef FLASH_BOOT_CHECKSUM_EN
                        if (trailer_q) begin
                            state_d = S_FINISH;
                        end else begin
                            cyc_d   = 1'b1;
                            state_d = S_WRITE;
                        end
`else
                        cyc_d   = 1'b1;
                        state_d = S_WRITE;
`endif
                    end else begin
                        sck_d = ~sck_q;
                        if (!sck_q) begin
                            // Rising edge: sample MISO. Completed bytes shift in
                            // from the top so the first byte ends in [7:0].
                            byte_d = {byte_q[5:0], i_flash_MISO};
                            if (bit_q[2:0] == 3'd7)
                                word_d = {byte_q, i_flash_MISO, word_q[31:8]};
                        end else begin
                            bit_d = bit_q + 6'd1;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_WRITE: begin
                if (i_wb_ack) begin
                    cyc_d = 1'b0;
                    div_d = '0;
                    bit_d = '0;
`ifdef FLASH_BOOT_CHECKSUM_EN
                    sum_d = sum_q + word_q;
`endif
                    if (idx_q == LAST_IDX) begin
`ifdef FLASH_BOOT_CHECKSUM_EN
                        trailer_d = 1'b1;
                        state_d   = S_DATA;
`else
                        state_d   = S_FINISH;
`endif
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_DATA;
                    end
                end
            end
            S_FINISH: begin
                if (div_tick) begin
                    csn_d     = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
`ifdef FLASH_BOOT_CHECKSUM_EN
                    err_d     = (word_q != sum_q);
                    cpu_rst_d = (word_q != sum_q);
`else
                    cpu_rst_d = 1'b0;
`endif
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: ;  // S_DONE is terminal until reset
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together from the values computed before the edge.
    always_ff @(posedge wb_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            cmd_q     <= '0;
            byte_q    <= '0;
            word_q    <= '0;
            idx_q     <= '0;
            sck_q     <= 1'b0;
            csn_q     <= 1'b1;
            cyc_q     <= 1'b0;
            done_q    <= 1'b0;
            cpu_rst_q <= 1'b1;
`ifdef FLASH_BOOT_CHECKSUM_EN
            sum_q     <= '0;
            trailer_q <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            cmd_q     <= cmd_d;
            byte_q    <= byte_d;
            word_q    <= word_d;
            idx_q     <= idx_d;
            sck_q     <= sck_d;
            csn_q     <= csn_d;
            cyc_q     <= cyc_d;
            done_q    <= done_d;
            cpu_rst_q <= cpu_rst_d;
`ifdef FLASH_BOOT_CHECKSUM_EN
            sum_q     <= sum_d;
            trailer_q <= trailer_d;
            err_q     <= err_d;
`endif
        end
    end

    assign o_flash_SCK  = sck_q;
    assign o_flash_CSn  = csn_q;
    assign o_flash_MOSI = cmd_q[31];
    assign o_wb_adr     = idx_q;
    assign o_wb_dat     = word_q;
    assign o_wb_sel     = cyc_q ? 4'hF : 4'h0;
    assign o_wb_we      = cyc_q;
    assign o_wb_cyc     = cyc_q;
    assign o_cpu_rst    = cpu_rst_q;
    assign o_done       = done_q;
`ifdef FLASH_BOOT_CHECKSUM_EN
    assign o_boot_err   = err_q;
`else
    assign o_boot_err   = 1'b0;
`endif

endmodule

// File: tb/tb_flash_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_flash_boot_loader
//
// Self-checking bench for flash_boot_loader (BOOT_WORDS=4, CLK_DIV=2).
// A behavioural SPI NOR model serves a byte image after decoding the READ
// command; a Wishbone responder acknowledges writes with programmable delay
// and logs them. Expected RAM words are built straight from the byte image.
// ---------------------------------------------------------------------------
module tb_flash_boot_loader;

    localparam int          BOOT_WORDS = 4;
    localparam int          CLK_DIV    = 2;
    localparam int          AW         = 11;
    localparam logic [23:0] FLASH_BASE = 24'h10_0000;
    localparam int          IMG_BYTES  = (BOOT_WORDS + 1) * 4;
    localparam int          BUDGET     = 5000;
`ifdef FLASH_BOOT_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic          wb_clk = 1'b0;
    logic          i_rstn;
    logic          i_boot_en;
    logic          i_flash_MISO;
    logic          i_wb_ack;
    logic          o_flash_SCK, o_flash_CSn, o_flash_MOSI;
    logic [AW-1:0] o_wb_adr;
    logic [31:0]   o_wb_dat;
    logic [3:0]    o_wb_sel;
    logic          o_wb_we, o_wb_cyc, o_cpu_rst, o_done, o_boot_err;

    flash_boot_loader #(
        .FLASH_BASE (FLASH_BASE),
        .BOOT_WORDS (BOOT_WORDS),
        .CLK_DIV    (CLK_DIV),
        .AW         (AW)
    ) dut (
        .wb_clk       (wb_clk),
        .i_rstn       (i_rstn),
        .i_boot_en    (i_boot_en),
        .o_flash_SCK  (o_flash_SCK),
        .o_flash_CSn  (o_flash_CSn),
        .o_flash_MOSI (o_flash_MOSI),
        .i_flash_MISO (i_flash_MISO),
        .o_wb_adr     (o_wb_adr),
        .o_wb_dat     (o_wb_dat),
        .o_wb_sel     (o_wb_sel),
        .o_wb_we      (o_wb_we),
        .o_wb_cyc     (o_wb_cyc),
        .i_wb_ack     (i_wb_ack),
        .o_cpu_rst    (o_cpu_rst),
        .o_done       (o_done),
        .o_boot_err   (o_boot_err)
    );

    always #5 wb_clk = ~wb_clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    int cyc_n = 0;
    initial forever begin
        @(posedge wb_clk);
        cyc_n = cyc_n + 1;
    end

    // ---------------- SPI NOR flash model ----------------
    logic [7:0]  flash_img [IMG_BYTES];
    logic [31:0] cmd_bits, cmd_log;
    logic [7:0]  cur_byte;
    int rise_cnt = 0, cmd_count = 0, csn_falls = 0;
    int csn_fall_cyc = 0, csn_rise_cyc = 0, first_rise_cyc = 0, last_rise_cyc = 0;
    int mosi_change_cyc = 0, period_viol = 0, setup_viol = 0, mosi_after_cmd = 0;
    int sbit, sbyte;

    initial forever begin
        @(negedge o_flash_CSn);
        rise_cnt     = 0;
        cmd_bits     = '0;
        csn_fall_cyc = cyc_n;
        csn_falls++;
    end

    initial forever begin
        @(posedge o_flash_CSn);
        csn_rise_cyc = cyc_n;
    end

    initial forever begin
        @(o_flash_MOSI);
        mosi_change_cyc = cyc_n;
    end

    initial forever begin
        @(posedge o_flash_SCK);
        if (!o_flash_CSn) begin
            if (rise_cnt == 0)
                first_rise_cyc = cyc_n;
            else if (rise_cnt < 32 && (cyc_n - last_rise_cyc) != 2 * CLK_DIV)
                period_viol++;
            last_rise_cyc = cyc_n;
            if (rise_cnt < 32) begin
                if (cyc_n - mosi_change_cyc < CLK_DIV) setup_viol++;
                cmd_bits = {cmd_bits[30:0], o_flash_MOSI};
                if (rise_cnt == 31) begin
                    cmd_log = cmd_bits;
                    cmd_count++;
                end
            end else if (o_flash_MOSI) begin
                mosi_after_cmd++;
            end
            rise_cnt++;
        end
    end

    // Mode 0: the flash shifts out the next data bit on each falling edge.
    initial begin
        i_flash_MISO = 1'b0;
        forever begin
            @(negedge o_flash_SCK);
            if (!o_flash_CSn && rise_cnt >= 32) begin
                sbit  = rise_cnt - 32;
                sbyte = sbit / 8;
                if (sbyte < IMG_BYTES) begin
                    cur_byte     = flash_img[sbyte];
                    i_flash_MISO = cur_byte[7 - (sbit % 8)];
                end else begin
                    i_flash_MISO = 1'b0;
                end
            end
        end
    end

    // ---------------- Wishbone write responder ----------------
    logic [31:0] wr_adr[$], wr_dat[$], wr_sel[$];
    int          wr_len[$];
    logic [AW-1:0] hold_adr;
    logic [31:0]   hold_dat;
    logic [3:0]    hold_sel;
    int  cyc_cnt = 0, cur_delay = 0, first_delay = 0;
    int  stab_viol = 0, pause_viol = 0, late_drop = 0, last_ack_cyc = 0;
    bit  acking = 1'b0, spurious_en = 1'b0;

    initial begin
        i_wb_ack = 1'b0;
        forever begin
            @(posedge wb_clk);
            #1;
            if (!i_rstn) begin
                acking   = 1'b0;
                i_wb_ack = 1'b0;
                cyc_cnt  = 0;
            end else if (acking) begin
                // Ack was sampled at this edge: the request must already be gone.
                acking   = 1'b0;
                i_wb_ack = 1'b0;
                if (o_wb_cyc) late_drop++;
                cyc_cnt  = 0;
            end else if (o_wb_cyc) begin
                if (cyc_cnt == 0) begin
                    hold_adr  = o_wb_adr;
                    hold_dat  = o_wb_dat;
                    hold_sel  = o_wb_sel;
                    cur_delay = (o_wb_adr == '0) ? first_delay : int'($urandom_range(0, 3));
                end else if (o_wb_adr !== hold_adr || o_wb_dat !== hold_dat ||
                             o_wb_sel !== hold_sel) begin
                    stab_viol++;
                end
                if (o_wb_we !== 1'b1) stab_viol++;
                if (o_flash_SCK || o_flash_CSn) pause_viol++;
                if (cyc_cnt == cur_delay) begin
                    i_wb_ack = 1'b1;
                    acking   = 1'b1;
                    last_ack_cyc = cyc_n;
                    wr_adr.push_back(32'(o_wb_adr));
                    wr_dat.push_back(o_wb_dat);
                    wr_sel.push_back(32'(o_wb_sel));
                    wr_len.push_back(cyc_cnt + 1);
                end else begin
                    i_wb_ack = 1'b0;
                end
                cyc_cnt++;
            end else begin
                // Stray acks while idle must be ignored by the loader.
                i_wb_ack = spurious_en ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] img_word(input int k);
        return {flash_img[4*k+3], flash_img[4*k+2], flash_img[4*k+1], flash_img[4*k]};
    endfunction

    // Random image; the trailer word is the word sum, plus 'bad' to corrupt it.
    task automatic fill_image(input bit fixed_head, input logic [31:0] bad);
        logic [31:0] sum;
        logic [31:0] trl;
        for (int i = 0; i < IMG_BYTES; i++) flash_img[i] = 8'($urandom);
        if (fixed_head)
            for (int i = 0; i < 8; i++) flash_img[i] = 8'(8'h11 * (i + 1));
        sum = '0;
        for (int k = 0; k < BOOT_WORDS; k++) sum = sum + img_word(k);
        trl = sum + bad;
        for (int b = 0; b < 4; b++) flash_img[4*BOOT_WORDS + b] = trl[8*b +: 8];
    endtask

    task automatic clear_logs();
        wr_adr.delete(); wr_dat.delete(); wr_sel.delete(); wr_len.delete();
        cmd_count = 0; csn_falls = 0; period_viol = 0; setup_viol = 0;
        mosi_after_cmd = 0; stab_viol = 0; pause_viol = 0; late_drop = 0;
        cmd_log = '0;
    endtask

    task automatic start_boot(input bit en);
        @(negedge wb_clk);
        i_rstn = 1'b0;
        clear_logs();
        i_boot_en = en;
        @(negedge wb_clk);
        i_rstn = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!o_done && n < BUDGET) begin
            @(posedge wb_clk);
            n++;
        end
        #1;
        check({tag, "_done_timeout"}, 32'(o_done), 32'd1);
    endtask

    task automatic verify_run(input string tag, input bit exp_err);
        int nw;
        check({tag, "_cmd"}, cmd_log, {8'h03, FLASH_BASE});
        check({tag, "_cmd_count"}, 32'(cmd_count), 32'd1);
        check({tag, "_first_rise"}, 32'(first_rise_cyc - csn_fall_cyc), 32'(CLK_DIV));
        check({tag, "_sck_period"}, 32'(period_viol), 32'd0);
        check({tag, "_mosi_setup"}, 32'(setup_viol), 32'd0);
        check({tag, "_mosi_idle"}, 32'(mosi_after_cmd), 32'd0);
        check({tag, "_nwrites"}, 32'(wr_adr.size()), 32'(BOOT_WORDS));
        nw = (wr_adr.size() < BOOT_WORDS) ? wr_adr.size() : BOOT_WORDS;
        for (int k = 0; k < nw; k++) begin
            check($sformatf("%s_adr%0d", tag, k), wr_adr[k], 32'(k));
            check($sformatf("%s_dat%0d", tag, k), wr_dat[k], img_word(k));
            check($sformatf("%s_sel%0d", tag, k), wr_sel[k], 32'hF);
        end
        check({tag, "_bus_stable"}, 32'(stab_viol), 32'd0);
        check({tag, "_spi_paused"}, 32'(pause_viol), 32'd0);
        check({tag, "_cyc_drop"}, 32'(late_drop), 32'd0);
        check({tag, "_csn_after_ack"}, 32'(csn_rise_cyc > last_ack_cyc), 32'd1);
        check({tag, "_csn_end"}, 32'(o_flash_CSn), 32'd1);
        check({tag, "_sck_end"}, 32'(o_flash_SCK), 32'd0);
        check({tag, "_cyc_end"}, 32'(o_wb_cyc), 32'd0);
        check({tag, "_cpu_rst"}, 32'(o_cpu_rst), 32'(exp_err));
        check({tag, "_boot_err"}, 32'(o_boot_err), 32'(exp_err));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        i_rstn    = 1'b0;
        i_boot_en = 1'b0;
        clear_logs();
        #23;

        // Reset state
        check("rst_sck",     32'(o_flash_SCK),  32'd0);
        check("rst_csn",     32'(o_flash_CSn),  32'd1);
        check("rst_mosi",    32'(o_flash_MOSI), 32'd0);
        check("rst_cyc",     32'(o_wb_cyc),     32'd0);
        check("rst_we",      32'(o_wb_we),      32'd0);
        check("rst_adr",     32'(o_wb_adr),     32'd0);
        check("rst_dat",     o_wb_dat,          32'd0);
        check("rst_sel",     32'(o_wb_sel),     32'd0);
        check("rst_cpu_rst", 32'(o_cpu_rst),    32'd1);
        check("rst_done",    32'(o_done),       32'd0);
        check("rst_err",     32'(o_boot_err),   32'd0);

        // Skip path
        start_boot(1'b0);
        @(posedge wb_clk);
        @(posedge wb_clk);
        #1;
        check("skip_done",    32'(o_done),    32'd1);
        check("skip_cpu_rst", 32'(o_cpu_rst), 32'd0);
        repeat (20) @(posedge wb_clk);
        #1;
        check("skip_no_csn",  32'(csn_falls),     32'd0);
        check("skip_no_wb",   32'(wr_adr.size()), 32'd0);

        // Fixed head 11..88, 7-cycle stall on word 0, stray acks while idle
        fill_image(1'b1, 32'd0);
        first_delay = 7;
        spurious_en = 1'b1;
        start_boot(1'b1);
        wait_done("pack");
        verify_run("pack", 1'b0);
        check("pack_w0", (wr_dat.size() > 0) ? wr_dat[0] : 32'hDEAD_BEEF, 32'h4433_2211);
        check("pack_w1", (wr_dat.size() > 1) ? wr_dat[1] : 32'hDEAD_BEEF, 32'h8877_6655);
        check("stall_len", (wr_len.size() > 0) ? 32'(wr_len[0]) : 32'd0, 32'd8);

        // Mid-transfer reset during word 1
        fill_image(1'b0, 32'd0);
        first_delay = 0;
        start_boot(1'b1);
        n = 0;
        while (wr_adr.size() < 1 && n < BUDGET) begin
            @(posedge wb_clk);
            n++;
        end
        check("midrst_reach_w1", 32'(wr_adr.size()), 32'd1);
        repeat (40) @(posedge wb_clk);
        #2;
        i_rstn = 1'b0;
        #1;
        check("midrst_csn",     32'(o_flash_CSn), 32'd1);
        check("midrst_sck",     32'(o_flash_SCK), 32'd0);
        check("midrst_cyc",     32'(o_wb_cyc),    32'd0);
        check("midrst_cpu_rst", 32'(o_cpu_rst),   32'd1);
        repeat (3) @(posedge wb_clk);
        #1;
        check("midrst_csn_hold", 32'(o_flash_CSn), 32'd1);
        clear_logs();
        @(negedge wb_clk);
        i_rstn = 1'b1;
        wait_done("midrst");
        verify_run("midrst", 1'b0);

        // Random images and random ack latencies
        for (int r = 0; r < 2; r++) begin
            fill_image(1'b0, 32'd0);
            first_delay = int'($urandom_range(0, 5));
            start_boot(1'b1);
            wait_done($sformatf("rand%0d", r));
            verify_run($sformatf("rand%0d", r), 1'b0);
        end

        // Corrupted trailer: only matters when the checksum feature is built in
        fill_image(1'b0, 32'd1);
        first_delay = 1;
        start_boot(1'b1);
        wait_done("badsum");
        verify_run("badsum", CSUM);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flash_boot_loader.md
Name: flash_boot_loader

Overview:
- Post-reset boot sequencer for the servant SoC. Reads a program image from the external SPI NOR flash (READ 0x03) and writes it word-by-word into on-chip RAM over a Wishbone write master.
- Holds the CPU in reset until the copy completes.
- Sits between the board-level flash pins and the SoC RAM port; the CPU sees a pre-loaded memory at RESET_ADDR.

Parameters:
- FLASH_BASE, 24'h10_0000, flash byte address of the image start.
- BOOT_WORDS, 2048, number of 32-bit words to copy (8192-byte memsize / 4).
- CLK_DIV, 2, wb_clk cycles per SCK half-period; legal range 1..255.
- AW, 11, word-address width of the RAM write port.

Ports:
- wb_clk  in  1  system clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_boot_en  in  1  sampled in IDLE; 1 = copy image, 0 = skip copy.
- o_flash_SCK  out  1  SPI clock, mode 0.
- o_flash_CSn  out  1  flash chip select, active low.
- o_flash_MOSI  out  1  SPI data to flash.
- i_flash_MISO  in  1  SPI data from flash.
- o_wb_adr  out  AW  RAM word address.
- o_wb_dat  out  32  RAM write data.
- o_wb_sel  out  4  byte enables, always 4'hF while o_wb_cyc=1.
- o_wb_we  out  1  write strobe, equals o_wb_cyc.
- o_wb_cyc  out  1  bus request (cyc and stb combined).
- i_wb_ack  in  1  write acknowledge.
- o_cpu_rst  out  1  CPU reset, active high.
- o_done  out  1  boot finished.
- o_boot_err  out  1  checksum failure.

Behaviour:
- Reset values (asynchronous, i_rstn=0):
  - SCK=0, CSn=1, MOSI=0.
  - wb_cyc=0, wb_we=0, wb_adr=0, wb_dat=0, wb_sel=0.
  - o_cpu_rst=1, o_done=0, o_boot_err=0.
  - State IDLE; all counters 0.
- IDLE: first cycle out of reset.
  - i_boot_en=0: go to DONE.
  - i_boot_en=1: drive CSn=0 and go to CMD.
- SPI timing:
  - Mode 0, MSB first.
  - Each SCK phase lasts exactly CLK_DIV cycles.
  - MOSI is updated only while SCK=0, and at least CLK_DIV cycles before each rising edge.
  - MISO is sampled in the cycle SCK goes 0->1.
  - First rising edge comes CLK_DIV cycles after CSn falls.
- CMD: shifts 32 bits on MOSI, {8'h03, FLASH_BASE}, then goes to DATA. MOSI is 0 after the command.
- DATA:
  - Shifts 8 bits per byte and packs 4 bytes little-endian: the first byte received lands in dat[7:0], the fourth in dat[31:24].
  - After the 4th byte's last rising edge, SCK returns low (CLK_DIV cycles), then go to WRITE.
- WRITE:
  - Asserts cyc/we with adr = word index and dat = assembled word.
  - Holds all bus outputs stable until i_wb_ack=1.
  - cyc deasserts in the cycle after ack.
  - SCK stays 0 and CSn stays 0 throughout, so the flash READ stream is paused, not restarted.
  - After ack: if word index = BOOT_WORDS-1, go to FINISH; else increment index and go to DATA.
- FINISH: SCK=0 for CLK_DIV cycles, then CSn=1, then go to DONE.
- DONE: terminal until reset.
  - o_done=1 and o_cpu_rst=0 from the first DONE cycle.
  - SCK=0, CSn=1, cyc=0.
- i_wb_ack outside WRITE is ignored.
- Reset asserted mid-transfer aborts immediately: CSn=1 and all outputs return to reset values. After release, the copy restarts from word 0 with a fresh READ command.
- Word index is AW bits wide. BOOT_WORDS must be <= 2^AW; no wrap-around occurs.
- Nominal duration per word: 32*2*CLK_DIV SPI cycles + CLK_DIV + ack latency + 1.

Optional Feature:
- Macro: FLASH_BOOT_CHECKSUM_EN.
- Defined:
  - A 32-bit modulo-2^32 sum accumulates every written word.
  - After the last write, one extra word is read in DATA but not written to RAM.
  - In FINISH, that extra word is compared with the sum.
  - Mismatch: enter DONE with o_boot_err=1 and o_cpu_rst held at 1; o_done=1.
  - Match: normal DONE.
- Undefined: no extra word is read and o_boot_err is tied 0.

Test Plan:
- Skip path: i_boot_en=0 -> o_done=1 and o_cpu_rst=0 within 2 cycles of reset release; CSn never goes low; no Wishbone cycle.
- Command and bit timing: BOOT_WORDS=2, CLK_DIV=2, flash model -> MOSI bits 0x03,0x10,0x00,0x00; SCK period 4 cycles; first rising edge 2 cycles after CSn falls.
- Data packing: flash bytes 11 22 33 44 55 66 77 88 -> writes adr0=32'h44332211, adr1=32'h88776655, sel=4'hF; CSn rises after the second ack.
- Ack stall: i_wb_ack delayed 7 cycles on word 0 -> cyc/adr/dat stable for 8 cycles; SCK held 0 and CSn held 0 during the stall; exactly one write per word.
- Mid-transfer reset: pull i_rstn low during word 1 of 4, release -> CSn high while in reset; new 0x03 command issued; writes resume at adr 0; all 4 words written.
- Checksum (FLASH_BOOT_CHECKSUM_EN, BOOT_WORDS=2): words 1 and 2 with trailer 3 -> o_cpu_rst=0, o_boot_err=0. Same words with trailer 4 -> o_boot_err=1, o_cpu_rst=1.
